ambi_led_scheduler: RTL
=======================

Name: ambi_led_scheduler

Overview:
- Sequences the 60 per-block averaged colours from the block-averaging stage out to the LED-strip serializer, one colour per valid/ready handshake.
- Snapshots the 24*NBLOCKS-bit framebuffer at the end of each vsync. It then walks the block indices 0..NBLOCKS-1 and inserts a strip latch gap after the last block.
- Sits between the averaging block (post_frame_vsync, framebuffer) and the WS2812-style bit serializer.

Parameters:
- NBLOCKS, 60, number of colour blocks / LEDs; framebuffer width is 24*NBLOCKS.
- LATCH_CYCLES, 4000, clk_pixel cycles the strip is held idle after the last LED (latch/reset gap); must be >= 1.
- FRAME_DIV, 1, transmit every FRAME_DIV-th eligible frame; 1 = every frame; range 1..255.

Ports:
- clk_pixel  input  1  module clock.
- rst_n  input  1  synchronous active-low reset.
- enable  input  1  1 = scheduling allowed; sampled only in IDLE.
- frame_vsync  input  1  vsync from the averaging block; its falling edge marks framebuffer valid.
- framebuffer  input  24*NBLOCKS  block colours; block j = bits [24j+23:24j], {B[7:0],R[7:0],G[7:0]}.
- led_data  output  24  colour presented to the serializer.
- led_valid  output  1  led_data/led_index valid.
- led_ready  input  1  serializer accepts when led_valid & led_ready.
- led_index  output  6  block index of led_data.
- busy  output  1  high in any state other than IDLE.
- frame_done  output  1  one-cycle pulse at the end of the latch gap.
- drop_count  output  8  saturating count of frames skipped due to overrun.

Behaviour:
- Reset (rst_n low at a clk_pixel edge) is synchronous:
  - all outputs go to 0; state = IDLE; pending = 0; frame-divider counter = 0; shadow contents don't-care.
  - Reset mid-transfer aborts immediately; led_valid drops the next cycle and no frame_done is issued.
- Edge detect: vs_d registered copy of frame_vsync; fall = vs_d & ~frame_vsync.
- Frame divider:
  - Each fall increments div_cnt, wrapping at FRAME_DIV-1.
  - A fall is eligible only when div_cnt == 0 before the increment.
- pending flag (single-depth):
  - Set by an eligible fall.
  - Cleared when IDLE consumes it.
  - An eligible fall while pending is already 1 increments drop_count (saturates at 255) and leaves pending at 1.
- FSM:
  - IDLE: if pending & enable -> LOAD; clear pending in the same cycle. If a new eligible fall coincides with that consume, pending stays 1 and no drop is counted.
  - LOAD (1 cycle): shadow <= framebuffer; idx <= 0 -> SEND.
  - SEND:
    - led_valid = 1, led_data = shadow[24*idx +: 24], led_index = idx.
    - On led_valid & led_ready: if idx == NBLOCKS-1 -> LATCH with gap counter = LATCH_CYCLES-1; else idx++ and stay.
    - led_data and led_index are registered and stable while led_valid & ~led_ready.
    - Back-to-back handshakes give one LED per cycle.
  - LATCH: led_valid = 0; count the gap down to 0, then frame_done = 1 for one cycle -> IDLE.
- Latency: an eligible fall with the FSM idle gives the first led_valid 3 cycles after the falling edge is sampled (edge detect, IDLE, LOAD).
- Minimum frame transfer: 2 + NBLOCKS + LATCH_CYCLES cycles.
- The shadow register isolates transmission from framebuffer updates during the following vsync.
- enable deasserted during SEND or LATCH does not abort the frame; it blocks only the next start. Pending falls still accumulate or drop while enable is low.

Optional Feature:
- AMBI_LED_GRB_ORDER_EN defined: led_data is reordered to {G,R,B}, i.e. {shadow[7:0], shadow[15:8], shadow[23:16]} per block, for GRB strips.
- Not defined: led_data passes the shadow slice unchanged as {B,R,G}.

Test Plan:
- Load block j with 24'h010000*j + j (block 5 = 24'h050005); enable = 1; one vsync pulse; led_ready tied 1 -> 60 consecutive handshakes with led_index 0..59 and matching data; first led_valid 3 cycles after the fall; frame_done 1 pulse after LATCH_CYCLES idle cycles; busy low afterwards.
- led_ready toggled randomly at 50% -> led_data/led_index held stable while unaccepted; no skipped or duplicated index; 60 transfers total.
- Three vsync falls during one transfer (LATCH_CYCLES = 4000) -> exactly one extra frame is sent after frame_done; drop_count = 2.
- FRAME_DIV = 3, 9 vsync pulses, idle FSM -> exactly 3 frames transmitted (falls 1, 4, 7); drop_count = 0.
- rst_n low for 1 cycle at idx = 30 -> next cycle led_valid = 0, busy = 0, drop_count = 0, no frame_done; the next vsync restarts at led_index 0.
- With AMBI_LED_GRB_ORDER_EN, block 0 = 24'hAABBCC -> led_data = 24'hCCBBAA; without the macro -> led_data = 24'hAABBCC.

Source files
------------

// File: rtl/ambi_led_scheduler.sv
// Frame scheduler: snapshots the block-colour framebuffer on vsync fall and streams one colour per handshake.
// Optional macro AMBI_LED_GRB_ORDER_EN reorders led_data to {G,R,B} for GRB strips.
module ambi_led_scheduler #(
  parameter int NBLOCKS      = 60,
  parameter int LATCH_CYCLES = 4000,
  parameter int FRAME_DIV    = 1
) (
  input  logic                   clk_pixel,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   frame_vsync,
  input  logic [24*NBLOCKS-1:0]  framebuffer,
  output logic [23:0]            led_data,
  output logic                   led_valid,
  input  logic                   led_ready,
  output logic [5:0]             led_index,
  output logic                   busy,
  output logic                   frame_done,
  output logic [7:0]             drop_count
);

  localparam int GW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_vsD;
  logic        r_pending;
  logic [7:0]  r_divCnt;
  logic [7:0]  r_dropCnt;
  logic [5:0]  r_idx;
  logic [GW-1:0] r_gap;
  logic [23:0] r_shadow [NBLOCKS];

  logic        w_fall;
  logic        w_elig;
  logic        w_consume;
  logic        w_lastIdx;
  logic [23:0] w_blk;

  assign w_fall    = r_vsD & ~frame_vsync;
  assign w_elig    = w_fall & (r_divCnt == 8'd0);
  assign w_consume = (r_state == IDLE) & r_pending & enable;
  assign w_lastIdx = (r_idx == 6'(NBLOCKS-1));
  assign w_blk     = r_shadow[r_idx];

  always_ff @(posedge clk_pixel) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    led_valid  = 1'b0;
    busy       = (r_state != IDLE);
    frame_done = 1'b0;
    unique case (r_state)
      IDLE:  if (r_pending && enable) w_next = LOAD;
      LOAD:  w_next = SEND;
      SEND: begin
        led_valid = 1'b1;
        if (led_ready && w_lastIdx) w_next = LATCH;
      end
      LATCH: begin
        if (r_gap == '0) begin
          frame_done = 1'b1;
          w_next     = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // A fall that coincides with IDLE consuming pending re-arms it without counting a drop.
  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      r_vsD     <= 1'b0;
      r_pending <= 1'b0;
      r_divCnt  <= 8'd0;
      r_dropCnt <= 8'd0;
      r_idx     <= 6'd0;
      r_gap     <= '0;
    end else begin
      r_vsD <= frame_vsync;
      if (w_fall)
        r_divCnt <= (r_divCnt == 8'(FRAME_DIV-1)) ? 8'd0 : r_divCnt + 8'd1;
      if (w_elig)         r_pending <= 1'b1;
      else if (w_consume) r_pending <= 1'b0;
      if (w_elig && r_pending && !w_consume && (r_dropCnt != 8'hFF))
        r_dropCnt <= r_dropCnt + 8'd1;
      case (r_state)
        LOAD: r_idx <= 6'd0;
        SEND: begin
          if (led_ready && !w_lastIdx) r_idx <= r_idx + 6'd1;
          if (led_ready && w_lastIdx)  r_gap <= GW'(LATCH_CYCLES-1);
        end
        LATCH: if (r_gap != '0) r_gap <= r_gap - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (r_state == LOAD)
      for (int j = 0; j < NBLOCKS; j++) r_shadow[j] <= framebuffer[24*j +: 24];
  end

`ifdef AMBI_LED_GRB_ORDER_EN
  assign led_data = led_valid ? {w_blk[7:0], w_blk[15:8], w_blk[23:16]} : 24'd0;
`else
  assign led_data = led_valid ? w_blk : 24'd0;
`endif

  assign led_index  = r_idx;
  assign drop_count = r_dropCnt;

endmodule
